// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - op codes and default widths shared by the pe_dbuf slice
package pe_pkg;

  localparam logic [2:0] OP_WS_FLOW   = 3'b000;
  localparam logic [2:0] OP_WS_LOAD   = 3'b001;
  localparam logic [2:0] OP_WS_SHADOW = 3'b010;
  localparam logic [2:0] OP_WS_SWAP   = 3'b011;
  localparam logic [2:0] OP_OS_FLOW   = 3'b100;
  localparam logic [2:0] OP_OS_DRAIN  = 3'b110;

  localparam int PE_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pe_dbuf_if.sv
// rtl/pe_dbuf_if.sv - neighbour-facing signal bundle of one processing element
// slave  : the PE; receives op/valid/act/wgt/result_in, drives the delayed forwards and result_out
// master : the upstream driver (neighbour PE or array edge)
interface pe_dbuf_if import pe_pkg::*; #(
  parameter int ACT_WIDTH    = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int PE_OUT_WIDTH = PE_DEFAULT_WIDTH
);

  logic [2:0]              operation_signal_in;
  logic                    valid_in;
  logic [ACT_WIDTH-1:0]    act_data_in;
  logic [WGT_WIDTH-1:0]    wgt_data_in;
  logic [PE_OUT_WIDTH-1:0] result_in;

  logic [2:0]              operation_signal_out;
  logic                    valid_out;
  logic [ACT_WIDTH-1:0]    act_data_out;
  logic [WGT_WIDTH-1:0]    wgt_data_out;
  logic [PE_OUT_WIDTH-1:0] result_out;

  modport slave (
    input  operation_signal_in, valid_in, act_data_in, wgt_data_in, result_in,
    output operation_signal_out, valid_out, act_data_out, wgt_data_out, result_out
  );

  modport master (
    output operation_signal_in, valid_in, act_data_in, wgt_data_in, result_in,
    input  operation_signal_out, valid_out, act_data_out, wgt_data_out, result_out
  );

endinterface

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - combinational a*b + addend, optional clamp under SATURATE_ACC_EN
// a, b   : operands (signed or unsigned per SIGNED)
// addend : psum or accumulator
// sum    : product extended to OUT_WIDTH plus addend
// sat    : clamp occurred this cycle (SATURATE_ACC_EN only)
module pe_mac #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int P_WIDTH   = 16,
  parameter int OUT_WIDTH = 32,
  parameter bit SIGNED    = 1'b1
) (
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [OUT_WIDTH-1:0] addend,
  output logic [OUT_WIDTH-1:0] sum
`ifdef SATURATE_ACC_EN
  , output logic               sat
`endif
);

  logic signed [P_WIDTH-1:0] a_x;
  logic signed [P_WIDTH-1:0] b_x;
  logic [P_WIDTH-1:0]        prod;
  logic [OUT_WIDTH-1:0]      prod_ext;

  // Operands are widened to the product width first so the multiply is not
  // truncated to the operand width; the low P_WIDTH bits are identical for
  // signed and unsigned interpretation once the extension is right.
  always_comb begin
    if (SIGNED) begin
      a_x      = P_WIDTH'($signed(a));
      b_x      = P_WIDTH'($signed(b));
      prod     = a_x * b_x;
      prod_ext = OUT_WIDTH'($signed(prod));
    end else begin
      a_x      = P_WIDTH'(a);
      b_x      = P_WIDTH'(b);
      prod     = a_x * b_x;
      prod_ext = OUT_WIDTH'(prod);
    end
  end

`ifdef SATURATE_ACC_EN
  logic [OUT_WIDTH:0] sum_full;

  always_comb begin
    sum_full = {1'b0, prod_ext} + {1'b0, addend};
    sum      = sum_full[OUT_WIDTH-1:0];
    sat      = 1'b0;
    if (SIGNED) begin
      // Overflow only when both terms share a sign and the result flips it;
      // the clamp direction follows the shared sign.
      if ((prod_ext[OUT_WIDTH-1] == addend[OUT_WIDTH-1]) &&
          (sum_full[OUT_WIDTH-1] != addend[OUT_WIDTH-1])) begin
        sat = 1'b1;
        sum = {addend[OUT_WIDTH-1], {(OUT_WIDTH-1){~addend[OUT_WIDTH-1]}}};
      end
    end else if (sum_full[OUT_WIDTH]) begin
      sat = 1'b1;
      sum = '1;
    end
  end
`else
  assign sum = prod_ext + addend;
`endif

endmodule

// File: rtl/pe_dbuf.sv
// rtl/pe_dbuf.sv - systolic PE: double-buffered weight-stationary and output-stationary modes
// clk, reset : clock, synchronous active-high reset
// bus        : pe_dbuf_if.slave (op/valid/act/wgt/result_in in, 1-cycle forwards and result_out)
// sat_flag   : sticky clamp indicator, present only with SATURATE_ACC_EN
module pe_dbuf import pe_pkg::*; #(
  parameter int ACT_WIDTH      = 8,
  parameter int WGT_WIDTH      = 8,
  parameter int MULT_OUT_WIDTH = ACT_WIDTH + WGT_WIDTH,
  parameter int PE_OUT_WIDTH   = PE_DEFAULT_WIDTH,
  parameter bit SIGNED         = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  pe_dbuf_if.slave bus
`ifdef SATURATE_ACC_EN
  , output logic   sat_flag
`endif
);

  logic [WGT_WIDTH-1:0]    w_active;
  logic [WGT_WIDTH-1:0]    w_shadow;
  logic [PE_OUT_WIDTH-1:0] acc;
  logic                    drained;
  logic [PE_OUT_WIDTH-1:0] ws_sum;
  logic [PE_OUT_WIDTH-1:0] os_sum;
`ifdef SATURATE_ACC_EN
  logic                    ws_sat;
  logic                    os_sat;
`endif

  // WS: act * w_active + incoming psum
  pe_mac #(
    .A_WIDTH(ACT_WIDTH), .B_WIDTH(WGT_WIDTH), .P_WIDTH(MULT_OUT_WIDTH),
    .OUT_WIDTH(PE_OUT_WIDTH), .SIGNED(SIGNED)
  ) u_ws_mac (
    .a(bus.act_data_in), .b(w_active), .addend(bus.result_in), .sum(ws_sum)
`ifdef SATURATE_ACC_EN
    , .sat(ws_sat)
`endif
  );

  // OS: act * streamed weight + local accumulator
  pe_mac #(
    .A_WIDTH(ACT_WIDTH), .B_WIDTH(WGT_WIDTH), .P_WIDTH(MULT_OUT_WIDTH),
    .OUT_WIDTH(PE_OUT_WIDTH), .SIGNED(SIGNED)
  ) u_os_mac (
    .a(bus.act_data_in), .b(bus.wgt_data_in), .addend(acc), .sum(os_sum)
`ifdef SATURATE_ACC_EN
    , .sat(os_sat)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_active                 <= '0;
      w_shadow                 <= '0;
      acc                      <= '0;
      drained                  <= 1'b0;
      bus.result_out           <= '0;
      bus.act_data_out         <= '0;
      bus.wgt_data_out         <= '0;
      bus.operation_signal_out <= '0;
      bus.valid_out            <= 1'b0;
`ifdef SATURATE_ACC_EN
      sat_flag                 <= 1'b0;
`endif
    end else begin
      // Forwards run every cycle so bubbles travel with valid_out=0.
      bus.act_data_out         <= bus.act_data_in;
      bus.wgt_data_out         <= bus.wgt_data_in;
      bus.operation_signal_out <= bus.operation_signal_in;
      bus.valid_out            <= bus.valid_in;
      if (bus.valid_in) begin
        case (bus.operation_signal_in)
          OP_WS_FLOW: begin
            bus.result_out <= ws_sum;
`ifdef SATURATE_ACC_EN
            sat_flag <= sat_flag | ws_sat;
`endif
          end
          OP_WS_LOAD: w_active <= bus.wgt_data_in;
          OP_WS_SHADOW: begin
            w_shadow       <= bus.wgt_data_in;
            bus.result_out <= ws_sum;
`ifdef SATURATE_ACC_EN
            sat_flag <= sat_flag | ws_sat;
`endif
          end
          OP_WS_SWAP: begin
            // ws_sum still uses the outgoing weight; the swap lands at this edge.
            bus.result_out <= ws_sum;
            w_active       <= w_shadow;
`ifdef SATURATE_ACC_EN
            sat_flag <= sat_flag | ws_sat;
`endif
          end
          OP_OS_FLOW: begin
            acc     <= os_sum;
            drained <= 1'b0;
`ifdef SATURATE_ACC_EN
            sat_flag <= sat_flag | os_sat;
`endif
          end
          OP_OS_DRAIN: begin
            // First drain emits the local sum; later drains pass the chain along.
            if (!drained) begin
              bus.result_out <= acc;
              acc            <= '0;
              drained        <= 1'b1;
            end else begin
              bus.result_out <= bus.result_in;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
